// File: rtl/decode_pkg.sv
// Shared definitions for the RV32I/RV64I decode stage: opcode map, format codes
// and the decoded control bundle held in the output register.
package decode_pkg;

  localparam logic [4:0] OPC_LOAD      = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM  = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
  localparam logic [4:0] OPC_AUIPC     = 5'b00101;
  localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
  localparam logic [4:0] OPC_STORE     = 5'b01000;
  localparam logic [4:0] OPC_OP        = 5'b01100;
  localparam logic [4:0] OPC_LUI       = 5'b01101;
  localparam logic [4:0] OPC_OP_32     = 5'b01110;
  localparam logic [4:0] OPC_BRANCH    = 5'b11000;
  localparam logic [4:0] OPC_JALR      = 5'b11001;
  localparam logic [4:0] OPC_JAL       = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM    = 5'b11100;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_t;

  // Width-independent part of a decoded instruction; imm/pc/indices are sized by the stage.
  typedef struct packed {
    fmt_t fmt;
    logic use_rs1;
    logic use_rs2;
    logic we_rd;
    logic invalid;
  } dec_ctrl_t;

  localparam dec_ctrl_t CTRL_RESET = '{fmt: FMT_NONE, use_rs1: 1'b0, use_rs2: 1'b0,
                                       we_rd: 1'b0, invalid: 1'b0};

endpackage

// File: rtl/decode_comb.sv
// Purely combinational instruction classifier: format, sign-extended immediate,
// register indices, operand-use flags and the illegal-encoding flag.
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int REG_W = 5
) (
  input  logic [31:0]      inst_i,
  output dec_ctrl_t        ctrl_o,
  output logic [XLEN-1:0]  imm_o,
  output logic [REG_W-1:0] rs1_o,
  output logic [REG_W-1:0] rs2_o,
  output logic [REG_W-1:0] rd_o
);

  logic [4:0]        opc;
  fmt_t              fmt;
  logic              nop;
  logic              use_rs1;
  logic              use_rs2;
  logic              we_rd;
  logic              reg_bad;
  logic              invalid;
  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sel;

  assign opc   = inst_i[6:2];
  assign rs1_o = inst_i[15 +: REG_W];
  assign rs2_o = inst_i[20 +: REG_W];
  assign rd_o  = inst_i[7 +: REG_W];

  assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u = {inst_i[31:12], 12'b0};
  assign imm_j = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  // MISC_MEM and SYSTEM decode as I-format but read and write nothing here.
  always_comb begin
    fmt = FMT_NONE;
    nop = 1'b0;
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: fmt = FMT_I;
      OPC_MISC_MEM, OPC_SYSTEM: begin
        fmt = FMT_I;
        nop = 1'b1;
      end
      OPC_AUIPC, OPC_LUI: fmt = FMT_U;
      OPC_STORE:          fmt = FMT_S;
      OPC_OP:             fmt = FMT_R;
      OPC_BRANCH:         fmt = FMT_B;
      OPC_JAL:            fmt = FMT_J;
      OPC_OP_IMM_32:      if (XLEN == 64) fmt = FMT_I;
      OPC_OP_32:          if (XLEN == 64) fmt = FMT_R;
      default:            fmt = FMT_NONE;
    endcase
  end

  assign use_rs1 = (fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) && !nop;
  assign use_rs2 = fmt inside {FMT_R, FMT_S, FMT_B};
  assign we_rd   = (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) && !nop && (inst_i[11:7] != 5'd0);

  // E base: any used register above x15 is illegal.
  assign reg_bad = (REG_W < 5) &&
                   ((use_rs1 && inst_i[19]) || (use_rs2 && inst_i[24]) || (we_rd && inst_i[11]));
  assign invalid = (inst_i[1:0] != 2'b11) || (fmt == FMT_NONE) || reg_bad;

  always_comb begin
    imm_sel = '0;
    case (fmt)
      FMT_I:   imm_sel = imm_i;
      FMT_S:   imm_sel = imm_s;
      FMT_B:   imm_sel = imm_b;
      FMT_U:   imm_sel = imm_u;
      FMT_J:   imm_sel = imm_j;
      default: imm_sel = '0;
    endcase
  end

  always_comb begin
    ctrl_o.fmt     = invalid ? FMT_NONE : fmt;
    ctrl_o.use_rs1 = use_rs1 && !invalid;
    ctrl_o.use_rs2 = use_rs2 && !invalid;
    ctrl_o.we_rd   = we_rd && !invalid;
    ctrl_o.invalid = invalid;
    imm_o          = invalid ? '0 : XLEN'(imm_sel);
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready output register around decode_comb plus a
// saturating count of accepted illegal instructions.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_imm,
  output logic [REG_W-1:0] out_rs1,
  output logic [REG_W-1:0] out_rs2,
  output logic [REG_W-1:0] out_rd,
  output logic [2:0]       out_fmt,
  output logic             out_use_rs1,
  output logic             out_use_rs2,
  output logic             out_we_rd,
  output logic             out_invalid,
  output logic [CNT_W-1:0] invalid_count
);

  dec_ctrl_t        dec_ctrl;
  logic [XLEN-1:0]  dec_imm;
  logic [REG_W-1:0] dec_rs1, dec_rs2, dec_rd;
  logic             accept;

  logic             valid_q, valid_d;
  dec_ctrl_t        ctrl_q, ctrl_d;
  logic [XLEN-1:0]  pc_q, pc_d, imm_q, imm_d;
  logic [REG_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  decode_comb #(.XLEN(XLEN), .REG_W(REG_W)) u_comb (
    .inst_i (in_inst),
    .ctrl_o (dec_ctrl),
    .imm_o  (dec_imm),
    .rs1_o  (dec_rs1),
    .rs2_o  (dec_rs2),
    .rd_o   (dec_rd)
  );

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Flush beats a simultaneous acceptance: the incoming word is dropped uncounted.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    pc_d    = pc_q;
    imm_d   = imm_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (flush)          valid_d = 1'b0;
    else if (accept)    valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
    if (accept) begin
      ctrl_d = dec_ctrl;
      pc_d   = in_pc;
      imm_d  = dec_imm;
      rs1_d  = dec_rs1;
      rs2_d  = dec_rs2;
      rd_d   = dec_rd;
      if (dec_ctrl.invalid && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_RESET;
      pc_q    <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_pc        = pc_q;
  assign out_imm       = imm_q;
  assign out_rs1       = rs1_q;
  assign out_rs2       = rs2_q;
  assign out_rd        = rd_q;
  assign out_fmt       = ctrl_q.fmt;
  assign out_use_rs1   = ctrl_q.use_rs1;
  assign out_use_rs2   = ctrl_q.use_rs2;
  assign out_we_rd     = ctrl_q.we_rd;
  assign out_invalid   = ctrl_q.invalid;
  assign invalid_count = cnt_q;

endmodule
